// File: rtl/sram16_slave.sv
`default_nettype none
// ============================================================================
// Module      : sram16_slave
// Description : Bus responder that turns each 32-bit transfer into two
//               halfword accesses on an external 16-bit asynchronous SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module sram16_slave #(
    parameter int ADDR_WIDTH  = 18,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [3:0]            sel_i,
    input  logic [31:0]           dat_i,
    output logic [31:0]           dat_o,
    output logic                  ack_o,
    output logic [ADDR_WIDTH:0]   sram_addr,
    output logic [15:0]           sram_dq_o,
    input  logic [15:0]           sram_dq_i,
    output logic                  sram_dq_oe,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic [1:0]            sram_be_n
);

    localparam logic [2:0] c_wait = 3'(WAIT_STATES);

    typedef enum logic [1:0] {
        c_idle    = 2'd0,
        c_access  = 2'd1,
        c_recover = 2'd2,
        c_ack     = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic [3:0]            r_sel;
    logic [31:0]           r_dat;
    logic                  r_half;
    logic                  r_abort;
    logic [2:0]            r_wcnt;

    logic                  w_half_nxt;
    logic                  w_start_access;
    logic                  w_req;
    logic                  w_ld_we;
    logic [ADDR_WIDTH-1:0] w_ld_adr;
    logic [3:0]            w_ld_sel;
    logic [31:0]           w_ld_dat;
    logic [15:0]           w_ld_half_dat;
    logic [1:0]            w_ld_be;
    logic                  w_capture;

    assign w_req = cyc_i && stb_i;

    // In IDLE the halfword setup comes straight from the bus; afterwards from the latched copy.
    assign w_ld_we       = (r_state == c_idle) ? we_i  : r_we;
    assign w_ld_adr      = (r_state == c_idle) ? adr_i : r_adr;
    assign w_ld_sel      = (r_state == c_idle) ? sel_i : r_sel;
    assign w_ld_dat      = (r_state == c_idle) ? dat_i : r_dat;
    assign w_ld_half_dat = w_half_nxt ? w_ld_dat[15:0] : w_ld_dat[31:16];
    assign w_ld_be       = w_ld_we ? ~(w_half_nxt ? w_ld_sel[1:0] : w_ld_sel[3:2]) : 2'b00;
    assign w_capture     = (r_state == c_access) && cyc_i && (r_wcnt == 3'd0) && !r_we;

    always_comb begin
        w_state_nxt    = r_state;
        w_half_nxt     = r_half;
        w_start_access = 1'b0;
        case (r_state)
            c_idle: begin
                if (w_req) begin
                    w_half_nxt = 1'b0;
                    // An empty write spends one quiet RECOVER cycle so its ack lands a clock later.
                    if (we_i && (sel_i == 4'b0000)) begin
                        w_state_nxt = c_recover;
                    end else begin
                        w_state_nxt    = c_access;
                        w_half_nxt     = we_i && (sel_i[3:2] == 2'b00);
                        w_start_access = 1'b1;
                    end
                end
            end
            c_access: begin
                if (!cyc_i || (r_wcnt == 3'd0)) begin
                    w_state_nxt = c_recover;
                end
            end
            c_recover: begin
                if (r_abort) begin
                    w_state_nxt = c_idle;
                end else if (!r_half && (!r_we || (r_sel[1:0] != 2'b00))) begin
                    w_state_nxt    = c_access;
                    w_half_nxt     = 1'b1;
                    w_start_access = 1'b1;
                end else begin
                    w_state_nxt = c_ack;
                end
            end
            c_ack: begin
                w_state_nxt = c_idle;
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_idle;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_sel   <= 4'b0000;
            r_dat   <= 32'd0;
            r_half  <= 1'b0;
            r_abort <= 1'b0;
            r_wcnt  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_half  <= w_half_nxt;
            if ((r_state == c_idle) && w_req) begin
                r_we    <= we_i;
                r_adr   <= adr_i;
                r_sel   <= sel_i;
                r_dat   <= dat_i;
                r_abort <= 1'b0;
            end else if ((r_state == c_access) && !cyc_i) begin
                r_abort <= 1'b1;
            end
            if (w_start_access) begin
                r_wcnt <= c_wait;
            end else if ((r_state == c_access) && (r_wcnt != 3'd0)) begin
                r_wcnt <= r_wcnt - 3'd1;
            end
        end
    end

    // Pad-side outputs are registered from the next state so they track the FSM exactly.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_o      <= 1'b0;
            dat_o      <= 32'd0;
            sram_addr  <= '0;
            sram_dq_o  <= 16'd0;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_be_n  <= 2'b11;
        end else begin
            ack_o      <= (w_state_nxt == c_ack);
            sram_ce_n  <= (w_state_nxt != c_access);
            sram_oe_n  <= !((w_state_nxt == c_access) && !w_ld_we);
            sram_we_n  <= !((w_state_nxt == c_access) && w_ld_we);
            sram_dq_oe <= w_ld_we && ((w_state_nxt == c_access) ||
                          ((w_state_nxt == c_recover) && (r_state == c_access)));
            if (w_start_access) begin
                sram_addr <= {w_ld_adr, w_half_nxt};
                sram_dq_o <= w_ld_half_dat;
                sram_be_n <= w_ld_be;
            end else if (w_state_nxt != c_access) begin
                sram_be_n <= 2'b11;
            end
            if (w_capture) begin
                if (r_half) begin
                    dat_o[15:0] <= sram_dq_i;
                end else begin
                    dat_o[31:16] <= sram_dq_i;
                end
            end
        end
    end

endmodule
`default_nettype wire
